// File: rtl/snx_mem_arbiter.sv
// Boot sequencer plus round-robin two-port arbiter in front of the SNX ROM/RAM pair.
// Copies BOOT_WORDS ROM words into RAM after reset, then time-shares the RAM between A and B.
module snx_mem_arbiter #(
   parameter int unsigned BOOT_WORDS = 1024,
   parameter int unsigned RAM_WORDS  = 1024
) (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [15:0] a_addr,
   input  logic [15:0] a_wdata,
   output logic        a_ack,
   output logic        a_rvalid,
   output logic [15:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [15:0] b_addr,
   input  logic [15:0] b_wdata,
   output logic        b_ack,
   output logic        b_rvalid,
   output logic [15:0] b_rdata,
   output logic        rom_read,
   output logic [15:0] rom_addr,
   input  logic [15:0] rom_out,
   output logic        ram_write,
   output logic        ram_read,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_in,
   input  logic [15:0] ram_out,
   output logic        boot_done
);

   typedef enum logic {StBoot, StRun} state_e;

   localparam state_e      ResetState = (BOOT_WORDS == 0) ? StRun : StBoot;
   localparam logic        ResetDone  = (BOOT_WORDS == 0);
   localparam logic [31:0] LastIdx    = 32'(BOOT_WORDS - 1);

   state_e      state_q;
   logic [15:0] cnt_q;
   logic        last_b_q;
   logic        boot_done_q;
   logic        a_rvalid_q, b_rvalid_q;
   logic [15:0] a_rdata_q, b_rdata_q;
   logic [15:0] ram_addr_q;

   logic        booting, running, grant_a, grant_b, granted;
   logic        sel_we, sel_in_range;
   logic [15:0] sel_addr, sel_wdata;

   always_comb begin
      booting      = !p_reset && (state_q == StBoot);
      running      = !p_reset && (state_q == StRun);
      // On contention the requester that was not granted last wins.
      grant_a      = running && a_req && (!b_req || last_b_q);
      grant_b      = running && b_req && !grant_a;
      granted      = grant_a || grant_b;
      sel_we       = grant_a ? a_we    : b_we;
      sel_addr     = grant_a ? a_addr  : b_addr;
      sel_wdata    = grant_a ? a_wdata : b_wdata;
      sel_in_range = {16'd0, sel_addr} < RAM_WORDS;
   end

   always_comb begin
      a_ack     = grant_a;
      b_ack     = grant_b;
      rom_read  = booting;
      rom_addr  = booting ? cnt_q : 16'd0;
      ram_write = booting || (granted && sel_we && sel_in_range);
      ram_read  = granted && !sel_we && sel_in_range;
      ram_in    = 16'd0;
      if (booting) begin
         ram_in = rom_out;
      end else if (granted && sel_we) begin
         ram_in = sel_wdata;
      end
      ram_addr = ram_addr_q;
      if (p_reset) begin
         ram_addr = 16'd0;
      end else if (booting) begin
         ram_addr = cnt_q;
      end else if (granted) begin
         ram_addr = sel_addr;
      end
      a_rvalid  = a_rvalid_q;
      b_rvalid  = b_rvalid_q;
      a_rdata   = a_rdata_q;
      b_rdata   = b_rdata_q;
      boot_done = boot_done_q;
   end

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         state_q     <= ResetState;
         cnt_q       <= 16'd0;
         last_b_q    <= 1'b1;
         boot_done_q <= ResetDone;
         a_rvalid_q  <= 1'b0;
         b_rvalid_q  <= 1'b0;
         a_rdata_q   <= 16'd0;
         b_rdata_q   <= 16'd0;
         ram_addr_q  <= 16'd0;
      end else begin
         a_rvalid_q <= grant_a && !a_we;
         b_rvalid_q <= grant_b && !b_we;
         unique case (state_q)
            StBoot: begin
               ram_addr_q <= cnt_q;
               cnt_q      <= cnt_q + 16'd1;
               if ({16'd0, cnt_q} == LastIdx) begin
                  state_q     <= StRun;
                  boot_done_q <= 1'b1;
               end
            end
            StRun: begin
               if (granted) begin
                  last_b_q   <= grant_b;
                  ram_addr_q <= sel_addr;
               end
               // Out-of-range reads still complete, returning zero.
               if (grant_a && !a_we) a_rdata_q <= sel_in_range ? ram_out : 16'd0;
               if (grant_b && !b_we) b_rdata_q <= sel_in_range ? ram_out : 16'd0;
            end
            default: state_q <= StBoot;
         endcase
      end
   end

endmodule

// File: tb/tb_snx_mem_arbiter.sv
// Scoreboard bench for snx_mem_arbiter: directed boot/arbitration cases plus random traffic
// checked against a transaction-level memory and round-robin model.
module tb_snx_mem_arbiter;

   localparam int unsigned BootWords = 4;
   localparam int unsigned RamWords  = 1024;

   logic        m_clock, p_reset;
   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_ack, a_rvalid, b_ack, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic        rom_read, ram_write, ram_read, boot_done;
   logic [15:0] rom_addr, rom_out, ram_addr, ram_in, ram_out;

   snx_mem_arbiter #(.BOOT_WORDS(BootWords), .RAM_WORDS(RamWords)) dut (
      .m_clock(m_clock), .p_reset(p_reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .rom_read(rom_read), .rom_addr(rom_addr), .rom_out(rom_out),
      .ram_write(ram_write), .ram_read(ram_read), .ram_addr(ram_addr),
      .ram_in(ram_in), .ram_out(ram_out), .boot_done(boot_done)
   );

   // Memory macros
   logic [15:0] rom_img [0:3];
   logic [15:0] env_ram [0:1023];
   assign rom_out = (rom_addr < 16'd4) ? rom_img[rom_addr[1:0]] : 16'h0BAD;
   assign ram_out = (ram_addr < 16'd1024) ? env_ram[ram_addr[9:0]] : 16'hDEAD;
   always @(posedge m_clock) begin
      if (ram_write && ram_addr < 16'd1024) env_ram[ram_addr[9:0]] <= ram_in;
   end

   initial m_clock = 1'b0;
   always #5 m_clock = ~m_clock;

   int cyc = 0;
   always @(posedge m_clock) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {logic a; logic b; logic wr; logic rd; logic [15:0] addr;} exp_t;
   typedef struct {int due; logic [15:0] data;} rd_t;
   exp_t exp_q[$];
   rd_t  a_rd_q[$];
   rd_t  b_rd_q[$];

   // Reference model: memory image and who was served last
   logic [15:0] m_mem [0:1023];
   logic        m_last_b;
   logic        mon_en = 1'b0;

   task automatic drive(input logic ar, input logic aw, input logic [15:0] aad,
                        input logic [15:0] awd, input logic br, input logic bw,
                        input logic [15:0] bad, input logic [15:0] bwd,
                        output logic ga, output logic gb);
      exp_t        e;
      rd_t         r;
      logic        we, inr;
      logic [15:0] ad, wd;
      a_req = ar; a_we = aw; a_addr = aad; a_wdata = awd;
      b_req = br; b_we = bw; b_addr = bad; b_wdata = bwd;
      ga = 1'b0; gb = 1'b0;
      if (ar && br) begin
         if (m_last_b) ga = 1'b1; else gb = 1'b1;
      end else if (ar) begin
         ga = 1'b1;
      end else if (br) begin
         gb = 1'b1;
      end
      if (ga || gb) m_last_b = gb;
      we = ga ? aw : bw;
      ad = ga ? aad : bad;
      wd = ga ? awd : bwd;
      inr = ad < 16'(RamWords);
      e.a = ga; e.b = gb; e.addr = ad;
      e.wr = (ga || gb) && we && inr;
      e.rd = (ga || gb) && !we && inr;
      if (e.wr) m_mem[ad[9:0]] = wd;
      if ((ga || gb) && !we) begin
         r.due  = cyc + 1;
         r.data = inr ? m_mem[ad[9:0]] : 16'h0000;
         if (ga) a_rd_q.push_back(r); else b_rd_q.push_back(r);
      end
      exp_q.push_back(e);
      @(posedge m_clock);
      #1;
   endtask

   always @(negedge m_clock) begin
      exp_t e;
      rd_t  r;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            chk("ack_queue_empty", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("a_ack", {31'd0, a_ack}, {31'd0, e.a});
            chk("b_ack", {31'd0, b_ack}, {31'd0, e.b});
            chk("ram_write", {31'd0, ram_write}, {31'd0, e.wr});
            chk("ram_read", {31'd0, ram_read}, {31'd0, e.rd});
            if (e.a || e.b) chk("ram_addr", {16'd0, ram_addr}, {16'd0, e.addr});
         end
         if (a_rd_q.size() > 0 && a_rd_q[0].due == cyc) begin
            r = a_rd_q.pop_front();
            chk("a_rvalid", {31'd0, a_rvalid}, 32'd1);
            chk("a_rdata", {16'd0, a_rdata}, {16'd0, r.data});
         end else begin
            chk("a_rvalid_idle", {31'd0, a_rvalid}, 32'd0);
         end
         if (b_rd_q.size() > 0 && b_rd_q[0].due == cyc) begin
            r = b_rd_q.pop_front();
            chk("b_rvalid", {31'd0, b_rvalid}, 32'd1);
            chk("b_rdata", {16'd0, b_rdata}, {16'd0, r.data});
         end else begin
            chk("b_rvalid_idle", {31'd0, b_rvalid}, 32'd0);
         end
      end
   end

   initial begin
      logic ga, gb;
      logic pa, pb, aw, bw;
      logic [15:0] aad, awd, bad, bwd;
      rom_img[0] = 16'h1111; rom_img[1] = 16'h2222;
      rom_img[2] = 16'h3333; rom_img[3] = 16'h4444;
      for (int i = 0; i < 1024; i++) begin
         env_ram[i] = 16'h0000;
         m_mem[i]   = 16'h0000;
      end
      for (int i = 0; i < 4; i++) m_mem[i] = rom_img[i];
      m_last_b = 1'b1;
      p_reset = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = 16'd0; a_wdata = 16'd0;
      b_req = 1'b0; b_we = 1'b0; b_addr = 16'd1; b_wdata = 16'd0;
      repeat (2) @(posedge m_clock);
      #1;
      chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
      chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
      chk("rst_rom_read", {31'd0, rom_read}, 32'd0);
      chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
      chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("rst_a_rdata", {16'd0, a_rdata}, 32'd0);

      // Boot with both requesters pending; reset again at cnt=2.
      p_reset = 1'b0; a_req = 1'b1; b_req = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge m_clock);
         chk("boot1_rom_addr", {16'd0, rom_addr}, k);
         chk("boot1_ram_write", {31'd0, ram_write}, 32'd1);
         chk("boot1_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
         @(posedge m_clock);
         #1;
      end
      p_reset = 1'b1;
      @(negedge m_clock);
      chk("midrst_ram_write", {31'd0, ram_write}, 32'd0);
      @(posedge m_clock);
      #1;
      p_reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge m_clock);
         chk("boot_ram_addr", {16'd0, ram_addr}, k);
         chk("boot_ram_in", {16'd0, ram_in}, {16'd0, rom_img[k]});
         chk("boot_rom_read", {31'd0, rom_read}, 32'd1);
         chk("boot_done_early", {31'd0, boot_done}, 32'd0);
         chk("boot_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
         @(posedge m_clock);
         #1;
      end
      chk("boot_done_rise", {31'd0, boot_done}, 32'd1);
      for (int k = 0; k < 4; k++) chk("boot_ram_copy", {16'd0, env_ram[k]}, {16'd0, rom_img[k]});

      mon_en = 1'b1;
      // Contention: A reads 0, B reads 1, both held; A first.
      for (int k = 0; k < 8; k++) drive(1, 0, 16'h0000, 16'h0, 1, 0, 16'h0001, 16'h0, ga, gb);
      // Single port write then read.
      drive(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, ga, gb);
      drive(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0, 16'h0, ga, gb);
      // Out of range on B.
      drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h0400, 16'h1234, ga, gb);
      drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0400, 16'h0000, ga, gb);
      // B streaming reads.
      for (int k = 0; k < 3; k++) drive(0, 0, 16'h0, 16'h0, 1, 0, 16'(k), 16'h0, ga, gb);

      // Random traffic; each requester holds its request until granted.
      pa = 0; pb = 0; aw = 0; bw = 0; aad = 0; awd = 0; bad = 0; bwd = 0;
      for (int k = 0; k < 400; k++) begin
         if (!pa && $urandom_range(0, 9) < 7) begin
            pa = 1; aw = 1'($urandom_range(0, 1)); awd = 16'($urandom);
            aad = ($urandom_range(0, 3) == 0) ? 16'(1020 + $urandom_range(0, 7))
                                              : 16'($urandom_range(0, 15));
         end
         if (!pb && $urandom_range(0, 9) < 7) begin
            pb = 1; bw = 1'($urandom_range(0, 1)); bwd = 16'($urandom);
            bad = ($urandom_range(0, 3) == 0) ? 16'(1020 + $urandom_range(0, 7))
                                              : 16'($urandom_range(0, 15));
         end
         drive(pa, aw, aad, awd, pb, bw, bad, bwd, ga, gb);
         if (ga) pa = 0;
         if (gb) pb = 0;
      end
      repeat (3) drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, ga, gb);
      mon_en = 1'b0;
      chk("drain_exp", exp_q.size(), 32'd0);
      chk("drain_a_rd", a_rd_q.size(), 32'd0);
      chk("drain_b_rd", b_rd_q.size(), 32'd0);

      // Reset from RUN: rdata cleared, boot restarts, requests ignored.
      drive(1, 0, 16'h0002, 16'h0, 0, 0, 16'h0, 16'h0, ga, gb);
      p_reset = 1'b1;
      @(posedge m_clock);
      #1;
      chk("rerst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("rerst_a_rdata", {16'd0, a_rdata}, 32'd0);
      chk("rerst_boot_done", {31'd0, boot_done}, 32'd0);
      chk("rerst_a_ack", {31'd0, a_ack}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
